// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide controller with HI/LO registers
// Results are computed at accept and held in pending registers until the latency counter expires.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [63:0] res;

  // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'b0, src_a} * {32'b0, src_b};
    abs_a  = src_a[31] ? (~src_a + 32'd1) : src_a;
    abs_b  = src_b[31] ? (~src_b + 32'd1) : src_b;
    mag_q  = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
    mag_r  = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
    sq     = (src_a[31] ^ src_b[31]) ? (~mag_q + 32'd1) : mag_q;
    sr     = src_a[31] ? (~mag_r + 32'd1) : mag_r;
    uq     = (src_b == 32'd0) ? 32'd0 : src_a / src_b;
    ur     = (src_b == 32'd0) ? 32'd0 : src_a % src_b;
    res    = {hi, lo};
    case (md_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (src_b != 32'd0) res = {sr, sq};
      OP_DIVU:  if (src_b != 32'd0) res = {ur, uq};
      default:  res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 32'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                p_hi  <= res[63:32];
                p_lo  <= res[31:0];
                cnt   <= 32'(MULT_CYCLES - 1);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                p_hi  <= res[63:32];
                p_lo  <= res[31:0];
                cnt   <= 32'(DIV_CYCLES - 1);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
          end else begin
            hi    <= p_hi;
            lo    <= p_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
